// File: rtl/regread_mux_pipe.sv
// Multi-port pipelined register read mux with write forwarding and valid/ready output stage.
// Optional REGREAD_XZR_EN: top entry (DEPTH-1) reads as zero (ARM XZR).
//
// state    | meaning
// ST_EMPTY | output register holds no result, rd_valid=0
// ST_FULL  | output register holds a result awaiting rd_ready, rd_valid=1
module regread_mux_pipe #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32,
  parameter int PORTS = 2,
  parameter int SELW  = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DEPTH-1:0][WIDTH-1:0]   in,
  input  logic                          wr_en,
  input  logic [SELW-1:0]               wr_addr,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic [PORTS-1:0]              rd_req,
  input  logic [PORTS-1:0][SELW-1:0]    rd_sel,
  output logic [PORTS-1:0]              rd_ack,
  output logic [PORTS-1:0]              rd_valid,
  input  logic [PORTS-1:0]              rd_ready,
  output logic [PORTS-1:0][WIDTH-1:0]   rd_data
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t           state_q  [PORTS];
  state_t           state_d  [PORTS];
  logic [WIDTH-1:0] data_q   [PORTS];
  logic [WIDTH-1:0] data_d   [PORTS];
  logic [WIDTH-1:0] cap_data [PORTS];
  logic [PORTS-1:0] sel_hit;

  // Decode loop only matches legal entries, so out-of-range selects fall through
  // to zero and can never pick up a forwarded write.
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      cap_data[p] = '0;
      sel_hit[p]  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (rd_sel[p] == SELW'(i)) begin
          cap_data[p] = in[i];
          sel_hit[p]  = 1'b1;
        end
      end
      if (sel_hit[p] && wr_en && (wr_addr == rd_sel[p])) cap_data[p] = wr_data;
`ifdef REGREAD_XZR_EN
      if (rd_sel[p] == SELW'(DEPTH - 1)) cap_data[p] = '0;
`endif
    end
  end

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      rd_ack[p]  = rd_req[p] & ((state_q[p] == ST_EMPTY) | rd_ready[p]);
      state_d[p] = state_q[p];
      data_d[p]  = data_q[p];
      case (state_q[p])
        ST_EMPTY: begin
          if (rd_ack[p]) begin
            state_d[p] = ST_FULL;
            data_d[p]  = cap_data[p];
          end
        end
        ST_FULL: begin
          if (rd_ready[p]) begin
            if (rd_req[p]) data_d[p] = cap_data[p];
            else           state_d[p] = ST_EMPTY;
          end
        end
        default: state_d[p] = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < PORTS; p++) begin
        state_q[p] <= ST_EMPTY;
        data_q[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        state_q[p] <= state_d[p];
        data_q[p]  <= data_d[p];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      rd_valid[p] = (state_q[p] == ST_FULL);
      rd_data[p]  = data_q[p];
    end
  end

endmodule

// File: tb/tb_regread_mux_pipe.sv
// Self-checking bench: default 32x64x2 instance and a 20-entry, 3-port, 16-bit instance,
// both compared against a per-port behavioural model of the read stage.
module tb_regread_mux_pipe;

  localparam int WA = 64, DA = 32, PA = 2, SA = 5;
  localparam int WB = 16, DB = 20, PB = 3, SB = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [DA-1:0][WA-1:0] in_a;
  logic                  wr_en_a;
  logic [SA-1:0]         wr_addr_a;
  logic [WA-1:0]         wr_data_a;
  logic [PA-1:0]         rd_req_a, rd_ack_a, rd_valid_a, rd_ready_a;
  logic [PA-1:0][SA-1:0] rd_sel_a;
  logic [PA-1:0][WA-1:0] rd_data_a;

  logic [DB-1:0][WB-1:0] in_b;
  logic                  wr_en_b;
  logic [SB-1:0]         wr_addr_b;
  logic [WB-1:0]         wr_data_b;
  logic [PB-1:0]         rd_req_b, rd_ack_b, rd_valid_b, rd_ready_b;
  logic [PB-1:0][SB-1:0] rd_sel_b;
  logic [PB-1:0][WB-1:0] rd_data_b;

  regread_mux_pipe #(.WIDTH(WA), .DEPTH(DA), .PORTS(PA)) dut_a (
    .clk(clk), .reset(reset), .in(in_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
    .wr_data(wr_data_a), .rd_req(rd_req_a), .rd_sel(rd_sel_a), .rd_ack(rd_ack_a),
    .rd_valid(rd_valid_a), .rd_ready(rd_ready_a), .rd_data(rd_data_a));

  regread_mux_pipe #(.WIDTH(WB), .DEPTH(DB), .PORTS(PB)) dut_b (
    .clk(clk), .reset(reset), .in(in_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
    .wr_data(wr_data_b), .rd_req(rd_req_b), .rd_sel(rd_sel_b), .rd_ack(rd_ack_b),
    .rd_valid(rd_valid_b), .rd_ready(rd_ready_b), .rd_data(rd_data_b));

  int n_tests = 0;
  int n_fail  = 0;

  logic            mv_a [PA];
  logic [WA-1:0]   md_a [PA];
  logic            mv_b [PB];
  logic [WB-1:0]   md_b [PB];

  task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_read(int sel, int depth, logic [63:0] entry,
                                           logic we, int wa, logic [63:0] wd);
    if (sel >= depth) return 64'h0;
`ifdef REGREAD_XZR_EN
    if (sel == depth - 1) return 64'h0;
`endif
    if (we && wa == sel) return wd;
    return entry;
  endfunction

  // Inputs are already driven; check ack, advance model across one edge, check outputs.
  task automatic step_a(string tag);
    logic ack;
    #1;
    for (int p = 0; p < PA; p++) begin
      ack = rd_req_a[p] & (~mv_a[p] | rd_ready_a[p]);
      check_val({tag, "_ack"}, 64'(rd_ack_a[p]), 64'(ack));
      if (ack) begin
        mv_a[p] = 1'b1;
        md_a[p] = ref_read(int'(rd_sel_a[p]), DA, in_a[rd_sel_a[p]],
                           wr_en_a, int'(wr_addr_a), wr_data_a);
      end else if (rd_ready_a[p]) mv_a[p] = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < PA; p++) begin
      check_val({tag, "_valid"}, 64'(rd_valid_a[p]), 64'(mv_a[p]));
      if (mv_a[p]) check_val({tag, "_data"}, rd_data_a[p], md_a[p]);
    end
  endtask

  task automatic step_b(string tag);
    logic ack;
    logic [63:0] ent;
    #1;
    for (int p = 0; p < PB; p++) begin
      ack = rd_req_b[p] & (~mv_b[p] | rd_ready_b[p]);
      check_val({tag, "_ack"}, 64'(rd_ack_b[p]), 64'(ack));
      if (ack) begin
        ent = (int'(rd_sel_b[p]) < DB) ? 64'(in_b[rd_sel_b[p]]) : 64'h0;
        mv_b[p] = 1'b1;
        md_b[p] = WB'(ref_read(int'(rd_sel_b[p]), DB, ent, wr_en_b,
                               int'(wr_addr_b), 64'(wr_data_b)));
      end else if (rd_ready_b[p]) mv_b[p] = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < PB; p++) begin
      check_val({tag, "_valid"}, 64'(rd_valid_b[p]), 64'(mv_b[p]));
      if (mv_b[p]) check_val({tag, "_data"}, 64'(rd_data_b[p]), 64'(md_b[p]));
    end
  endtask

  task automatic clear_model();
    for (int p = 0; p < PA; p++) begin mv_a[p] = 1'b0; md_a[p] = '0; end
    for (int p = 0; p < PB; p++) begin mv_b[p] = 1'b0; md_b[p] = '0; end
  endtask

  initial begin
    reset = 1'b0;
    in_a = '0; wr_en_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
    rd_req_a = '0; rd_ready_a = '0; rd_sel_a = '0;
    in_b = '0; wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
    rd_req_b = '0; rd_ready_b = '0; rd_sel_b = '0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    for (int p = 0; p < PA; p++) begin
      check_val("rst_valid", 64'(rd_valid_a[p]), 64'h0);
      check_val("rst_data", rd_data_a[p], 64'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Basic sweep on port 0
    for (int i = 0; i < DA; i++) in_a[i] = 64'hA + 64'(i);
    rd_req_a = 2'b01; rd_ready_a = 2'b11;
    for (int i = 0; i < DA; i++) begin
      rd_sel_a[0] = SA'(i);
      step_a("sweep");
    end
    rd_req_a = 2'b00;
    step_a("drain");

    // Forwarding hit and miss on both ports
    in_a[5] = 64'h1111;
    wr_en_a = 1'b1; wr_addr_a = 5'd5; wr_data_a = 64'hDEAD;
    rd_sel_a[0] = 5'd5; rd_sel_a[1] = 5'd5; rd_req_a = 2'b11;
    step_a("fwd_hit");
    check_val("fwd_hit_p0", rd_data_a[0], 64'hDEAD);
    check_val("fwd_hit_p1", rd_data_a[1], 64'hDEAD);
    wr_addr_a = 5'd6;
    step_a("fwd_miss");
    check_val("fwd_miss_p0", rd_data_a[0], 64'h1111);
    check_val("fwd_miss_p1", rd_data_a[1], 64'h1111);
    wr_en_a = 1'b0; rd_req_a = 2'b00;
    step_a("drain");

    // Backpressure on port 1
    in_a[3] = 64'hA + 64'd3;
    rd_sel_a[1] = 5'd3; rd_req_a = 2'b10; rd_ready_a = 2'b11;
    step_a("bp_load");
    rd_ready_a[1] = 1'b0; rd_sel_a[1] = 5'd7;
    wr_en_a = 1'b1; wr_addr_a = 5'd3; wr_data_a = 64'hBEEF;
    for (int k = 0; k < 4; k++) begin
      step_a("bp_hold");
      check_val("bp_hold_d", rd_data_a[1], 64'hD);
    end
    wr_en_a = 1'b0; rd_ready_a[1] = 1'b1;
    step_a("bp_release");
    check_val("bp_next", rd_data_a[1], 64'hA + 64'd7);
    rd_req_a = 2'b00;
    step_a("drain");

    // Top entry with forwarding
    in_a[31] = 64'hFFFF;
    wr_en_a = 1'b1; wr_addr_a = 5'd31; wr_data_a = 64'h5;
    rd_sel_a[0] = 5'd31; rd_sel_a[1] = 5'd31; rd_req_a = 2'b11;
    step_a("xzr");
`ifdef REGREAD_XZR_EN
    check_val("xzr_p0", rd_data_a[0], 64'h0);
`else
    check_val("xzr_p0", rd_data_a[0], 64'h5);
`endif
    wr_en_a = 1'b0;

    // Random traffic on the default instance
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < DA; i++) in_a[i] = {$urandom, $urandom};
      wr_en_a   = 1'($urandom_range(0, 1));
      wr_addr_a = SA'($urandom_range(0, DA - 1));
      wr_data_a = {$urandom, $urandom};
      for (int p = 0; p < PA; p++) begin
        rd_req_a[p]   = ($urandom_range(0, 3) != 0);
        rd_ready_a[p] = ($urandom_range(0, 3) != 0);
        rd_sel_a[p]   = ($urandom_range(0, 1) != 0) ? wr_addr_a : SA'($urandom_range(0, DA - 1));
      end
      step_a("rand_a");
    end

    // Asynchronous reset mid-stream with both ports full and held
    rd_req_a = 2'b11; rd_ready_a = 2'b11; rd_sel_a[0] = 5'd1; rd_sel_a[1] = 5'd2;
    step_a("pre_rst");
    rd_ready_a = 2'b00;
    #2;
    reset = 1'b0;
    #1;
    check_val("arst_valid", 64'(rd_valid_a), 64'h0);
    check_val("arst_data0", rd_data_a[0], 64'h0);
    check_val("arst_data1", rd_data_a[1], 64'h0);
    clear_model();
    rd_req_a = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    in_a[9] = 64'h9999_0000_1234;
    rd_sel_a[0] = 5'd9; rd_req_a = 2'b01; rd_ready_a = 2'b11;
    step_a("post_rst");
    check_val("post_rst_d", rd_data_a[0], 64'h9999_0000_1234);
    rd_req_a = 2'b00; rd_ready_a = 2'b00;

    // Non-power-of-two instance
    for (int i = 0; i < DB; i++) in_b[i] = 16'h100 + 16'(i);
    rd_ready_b = 3'b111; rd_req_b = 3'b111;
    rd_sel_b[0] = 5'd25; rd_sel_b[1] = 5'd19; rd_sel_b[2] = 5'd0;
    step_b("np2");
    check_val("np2_oob", 64'(rd_data_b[0]), 64'h0);
`ifdef REGREAD_XZR_EN
    check_val("np2_top", 64'(rd_data_b[1]), 64'h0);
`else
    check_val("np2_top", 64'(rd_data_b[1]), 64'h113);
`endif
    wr_en_b = 1'b1; wr_addr_b = 5'd25; wr_data_b = 16'hCAFE;
    step_b("np2_oob_wr");
    wr_en_b = 1'b0;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < DB; i++) in_b[i] = 16'($urandom);
      wr_en_b   = 1'($urandom_range(0, 1));
      wr_addr_b = SB'($urandom_range(0, 31));
      wr_data_b = 16'($urandom);
      for (int p = 0; p < PB; p++) begin
        rd_req_b[p]   = ($urandom_range(0, 3) != 0);
        rd_ready_b[p] = ($urandom_range(0, 3) != 0);
        rd_sel_b[p]   = ($urandom_range(0, 1) != 0) ? wr_addr_b : SB'($urandom_range(0, 31));
      end
      step_b("rand_b");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
